inst_loader: RTL and testbench
==============================

# inst_loader

Program loader for the pipeline's instruction memory. It takes a byte stream from the debug UART receiver, assembles 32-bit big-endian instruction words and drives the instruction-memory write port of the fetch stage: write strobe, word data and byte address. Loading stops at the HALT word or when memory is full. The fetch stage holds the write interface; this block is its writer.

## Interface
- INST_SZ, 32, instruction word width; must equal 4 × BYTE_SZ
- PC_SZ, 32, address width; byte addresses
- BYTE_SZ, 8, width of one received byte
- MEM_DEPTH, 256, instruction memory depth in words; power of two
- HALT_INST, 32'hFFFF_FFFF, end-of-program word

- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  level/pulse; starts a load session from IDLE or DONE
- i_rx_data  in  BYTE_SZ  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle
- o_write  out  1  instruction-memory write strobe (to fetch-stage write enable)
- o_instruction  out  INST_SZ  word to write (to fetch-stage instruction input)
- o_addr  out  PC_SZ  byte address of the word being written
- o_busy  out  1  high in RECV and WRITE
- o_done  out  1  high in DONE
- o_overflow  out  1  DONE reached by filling memory without HALT
- o_inst_count  out  $clog2(MEM_DEPTH)+1  words written this session, HALT included

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: i_rx_valid is ignored. On i_start: clear the address, word count, byte index and o_overflow, then go to RECV.
- RECV: on each i_rx_valid, shift the byte into the assembly register. The first byte lands in [31:24] and the fourth in [7:0]. The byte index counts 0..3. On the fourth byte, latch the word into o_instruction and go to WRITE.
- WRITE lasts exactly one cycle:
  - o_write=1, with o_addr = 4 × word_index.
  - Next cycle: o_addr += 4 and o_inst_count += 1.
  - If the word equals HALT_INST, go to DONE with o_overflow=0.
  - Else if o_inst_count+1 == MEM_DEPTH, go to DONE with o_overflow=1.
  - Else go to RECV.
- A byte arriving in the WRITE cycle is captured as byte 0 of the next word. None are dropped.
- i_start during RECV or WRITE is ignored.
- DONE: i_rx_valid is ignored; outputs hold. i_start restarts the session, as from IDLE.
- A partial word (fewer than 4 bytes) is never written.
- Address arithmetic: word_index has width $clog2(MEM_DEPTH). o_addr is word_index zero-extended to PC_SZ, then shifted left by 2. There is no wrap, because the overflow stop happens first.

## Timing
- Reset values: all outputs 0, state IDLE, assembly register 0.
- Reset asserted mid-session aborts immediately and asynchronously. A pending write is not issued.
- Latency: fourth-byte strobe at cycle n produces o_write high in cycle n+1, single cycle.
- o_instruction and o_addr are registered and stable in the o_write cycle. o_instruction holds its value afterward.
- Minimum byte spacing: back-to-back strobes (every cycle) are supported.
- o_done rises the cycle after the final WRITE.
- o_busy is 0 in the same cycle o_done is 1.

## Structure
- Shared pipeline package holds:
  - HALT_INST constant
  - FSM state encoding typedef (2 bits)
  - BYTE_SZ constant, shared with the UART receiver
- One natural sub-module: `byte_assembler`. It holds the shift register, the 2-bit byte index and a word-ready pulse.
- The FSM and address/count registers stay in inst_loader.
- All outputs come from registers; no combinational paths from inputs to outputs.

## Test plan
- Basic load: reset, i_start, bytes 20 08 00 05, then FF FF FF FF.
  - Cycle after the 4th byte: o_write=1, o_instruction=32'h2008_0005, o_addr=0.
  - Cycle after the 8th byte: o_write=1, o_instruction=32'hFFFF_FFFF, o_addr=4.
  - Then o_done=1, o_inst_count=2, o_overflow=0.
- Back-to-back: 12 bytes on consecutive cycles, the last word being HALT.
  - Three o_write pulses, at addresses 0, 4 and 8, with data intact.
- Overflow with MEM_DEPTH=4: send 4 non-HALT words.
  - Writes at 0, 4, 8 and 12, then o_done=1, o_overflow=1, o_inst_count=4.
  - Further bytes produce no o_write.
- Ignore rules:
  - Bytes in IDLE and in DONE: no o_write.
  - i_start after 2 bytes: no restart; the word completes normally.
- Reset mid-session: assert i_reset after 3 bytes.
  - All outputs read 0 immediately and no write occurs.
  - A new session then writes its first word at address 0.
- Restart from DONE: i_start in DONE.
  - o_done=0, o_inst_count=0, and the next word is written at address 0.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared pipeline definitions for the instruction loader and the debug UART path.
// Holds the end-of-program word, the byte width and the loader FSM encoding.
package inst_loader_pkg;

  localparam int          BYTE_SZ   = 8;
  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Collects four received bytes, most significant first, into one instruction word.
// o_word_ready flags the strobe carrying the fourth byte; o_word is the finished word in that cycle.
module byte_assembler #(
  parameter int BYTE_SZ = inst_loader_pkg::BYTE_SZ
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_enable,
  input  logic [BYTE_SZ-1:0]   i_rx_data,
  input  logic                 i_rx_valid,
  output logic [4*BYTE_SZ-1:0] o_word,
  output logic                 o_word_ready
);

  logic [4*BYTE_SZ-1:0] r_shift;
  logic [1:0]           r_idx;
  logic                 w_take;

  assign w_take       = i_enable & i_rx_valid;
  assign o_word       = {r_shift[3*BYTE_SZ-1:0], i_rx_data};
  assign o_word_ready = w_take & (r_idx == 2'd3);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_idx   <= '0;
    end else if (w_take) begin
      r_shift <= o_word;
      r_idx   <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction-memory program loader: turns a UART byte stream into big-endian words
// and writes them at consecutive byte addresses until HALT or memory full.
module inst_loader #(
  parameter int                 INST_SZ   = 32,
  parameter int                 PC_SZ     = 32,
  parameter int                 BYTE_SZ   = inst_loader_pkg::BYTE_SZ,
  parameter int                 MEM_DEPTH = 256,
  parameter logic [INST_SZ-1:0] HALT_INST = inst_loader_pkg::HALT_INST
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [BYTE_SZ-1:0]          i_rx_data,
  input  logic                        i_rx_valid,
  output logic                        o_write,
  output logic [INST_SZ-1:0]          o_instruction,
  output logic [PC_SZ-1:0]            o_addr,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_overflow,
  output logic [$clog2(MEM_DEPTH):0]  o_inst_count
);

  import inst_loader_pkg::*;

  localparam int CW = $clog2(MEM_DEPTH) + 1;

  state_t             r_state;
  logic               r_write;
  logic [INST_SZ-1:0] r_instruction;
  logic [PC_SZ-1:0]   r_addr;
  logic               r_busy;
  logic               r_done;
  logic               r_overflow;
  logic [CW-1:0]      r_count;

  logic               w_idle_or_done;
  logic               w_clear;
  logic               w_assemble;
  logic [INST_SZ-1:0] w_word;
  logic               w_word_ready;

  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_clear        = w_idle_or_done & i_start;
  // Bytes are accepted in WRITE too, so a strobe there becomes byte 0 of the next word.
  assign w_assemble     = (r_state == ST_RECV) || (r_state == ST_WRITE);

  byte_assembler #(
    .BYTE_SZ(BYTE_SZ)
  ) u_byte_assembler (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_clear),
    .i_enable    (w_assemble),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_word      (w_word),
    .o_word_ready(w_word_ready)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_write       <= 1'b0;
      r_instruction <= '0;
      r_addr        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_count       <= '0;
    end else begin
      r_write <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_state    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (w_word_ready) begin
            r_instruction <= w_word;
            r_write       <= 1'b1;
            r_state       <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_addr  <= r_addr + PC_SZ'(4);
          r_count <= r_count + CW'(1);
          if (r_instruction == HALT_INST) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_overflow <= 1'b0;
          end else if ((r_count + CW'(1)) == CW'(MEM_DEPTH)) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_overflow <= 1'b1;
          end else begin
            r_state    <= ST_RECV;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_write       = r_write;
  assign o_instruction = r_instruction;
  assign o_addr        = r_addr;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_overflow    = r_overflow;
  assign o_inst_count  = r_count;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: a full-depth and a 4-word instance share one byte stream and
// are each compared against a word-grouping model of the load session.
module tb_inst_loader;
  import inst_loader_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        wr_a, busy_a, done_a, ovf_a;
  logic [31:0] ins_a, addr_a;
  logic [8:0]  cnt_a;
  logic        wr_b, busy_b, done_b, ovf_b;
  logic [31:0] ins_b, addr_b;
  logic [2:0]  cnt_b;

  logic [8:0]  obs_cnt [2];
  logic        obs_done[2];
  logic        obs_ovf [2];

  int          checks = 0;
  int          errors = 0;
  wr_t         got[2][$];
  wr_t         exp_q[2][$];
  int          exp_cnt[2];
  logic        exp_done[2];
  logic        exp_ovf[2];
  logic [7:0]  bytes[$];

  always #5 clk = ~clk;

  inst_loader #(.MEM_DEPTH(256)) u_dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_write(wr_a), .o_instruction(ins_a), .o_addr(addr_a), .o_busy(busy_a),
    .o_done(done_a), .o_overflow(ovf_a), .o_inst_count(cnt_a)
  );

  inst_loader #(.MEM_DEPTH(4)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_write(wr_b), .o_instruction(ins_b), .o_addr(addr_b), .o_busy(busy_b),
    .o_done(done_b), .o_overflow(ovf_b), .o_inst_count(cnt_b)
  );

  assign obs_cnt[0]  = cnt_a;
  assign obs_cnt[1]  = {6'd0, cnt_b};
  assign obs_done[0] = done_a;
  assign obs_done[1] = done_b;
  assign obs_ovf[0]  = ovf_a;
  assign obs_ovf[1]  = ovf_b;

  always @(negedge clk) begin
    if (wr_a) got[0].push_back('{addr_a, ins_a});
    if (wr_b) got[1].push_back('{addr_b, ins_b});
    if (done_a || done_b) begin
      checks++;
      if ((done_a && busy_a) || (done_b && busy_b)) begin
        errors++;
        $display("FAIL busy_with_done: busy_a=%0b done_a=%0b busy_b=%0b done_b=%0b, busy must be 0 when done",
                 busy_a, done_a, busy_b, done_b);
      end
    end
  end

  // Expected session result: bytes grouped into words in order, stopping at HALT or when full.
  function automatic void compute_expected();
    for (int d = 0; d < 2; d++) begin
      int   depth;
      int   cnt;
      logic ovf;
      logic halted;
      depth  = (d == 0) ? 256 : 4;
      cnt    = 0;
      ovf    = 1'b0;
      halted = 1'b0;
      exp_q[d].delete();
      for (int k = 0; 4 * k + 3 < bytes.size(); k++) begin
        logic [31:0] w;
        w = {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]};
        exp_q[d].push_back('{32'(4 * k), w});
        cnt++;
        if (w == HALT_INST) begin halted = 1'b1; break; end
        if (cnt == depth) begin ovf = 1'b1; break; end
      end
      exp_cnt[d]  = cnt;
      exp_ovf[d]  = ovf;
      exp_done[d] = halted | ovf;
    end
  endfunction

  function automatic void gen_words(input int n, input bit with_halt);
    bytes.delete();
    for (int k = 0; k < n; k++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == HALT_INST) w = 32'h0;
      for (int j = 3; j >= 0; j--) bytes.push_back(w[8*j +: 8]);
    end
    if (with_halt) repeat (4) bytes.push_back(8'hFF);
  endfunction

  task automatic clear_got();
    got[0].delete();
    got[1].delete();
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send(input int lo, input int hi, input int gap_max);
    for (int i = lo; i <= hi; i++) begin
      int g;
      g = $urandom_range(gap_max, 0);
      repeat (g) begin
        @(posedge clk); #1 rx_valid = 1'b0; rx_data = 8'($urandom);
      end
      @(posedge clk); #1 rx_valid = 1'b1; rx_data = bytes[i];
    end
    @(posedge clk); #1 rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_a, ins_a, addr_a, busy_a, done_a, ovf_a, cnt_a} !== 77'd0) begin
      errors++;
      $display("FAIL reset_a: outputs=%h, required all zero", {wr_a, ins_a, addr_a, busy_a, done_a, ovf_a, cnt_a});
    end
    checks++;
    if ({wr_b, ins_b, addr_b, busy_b, done_b, ovf_b, cnt_b} !== 71'd0) begin
      errors++;
      $display("FAIL reset_b: outputs=%h, required all zero", {wr_b, ins_b, addr_b, busy_b, done_b, ovf_b, cnt_b});
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] seq[8];
    seq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    clear_got();
    do_start();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        checks++;
        if (wr_a !== 1'b0) begin
          errors++; $display("FAIL basic_early_write: o_write=%0b before 4th byte, required 0", wr_a);
        end
      end
      if (i == 4) begin
        checks++;
        if (wr_a !== 1'b1 || ins_a !== 32'h2008_0005 || addr_a !== 32'd0) begin
          errors++;
          $display("FAIL basic_word0: write=%0b data=%h addr=%0d, required 1 20080005 0", wr_a, ins_a, addr_a);
        end
      end
      rx_valid = 1'b1; rx_data = seq[i];
    end
    @(posedge clk); #1 rx_valid = 1'b0;
    checks++;
    if (wr_a !== 1'b1 || ins_a !== 32'hFFFF_FFFF || addr_a !== 32'd4) begin
      errors++;
      $display("FAIL basic_word1: write=%0b data=%h addr=%0d, required 1 ffffffff 4", wr_a, ins_a, addr_a);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1 || cnt_a !== 9'd2 || ovf_a !== 1'b0 || wr_a !== 1'b0 || ins_a !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL basic_done: done=%0b count=%0d ovf=%0b write=%0b data=%h, required 1 2 0 0 ffffffff",
               done_a, cnt_a, ovf_a, wr_a, ins_a);
    end
    checks++;
    if (got[0].size() !== 2 || got[1].size() !== 2) begin
      errors++; $display("FAIL basic_nwrites: a=%0d b=%0d, required 2 2", got[0].size(), got[1].size());
    end
  endtask

  task automatic test_session(input string name, input int nwords, input int gap_max, input bit restart_chk);
    gen_words(nwords, 1'b1);
    compute_expected();
    clear_got();
    do_start();
    if (restart_chk) begin
      checks++;
      if (done_a !== 1'b0 || cnt_a !== 9'd0 || busy_a !== 1'b1 || done_b !== 1'b0 || cnt_b !== 3'd0) begin
        errors++;
        $display("FAIL %s_restart: done=%0b count=%0d busy=%0b done_b=%0b count_b=%0d, required 0 0 1 0 0",
                 name, done_a, cnt_a, busy_a, done_b, cnt_b);
      end
    end
    send(0, bytes.size() - 1, gap_max);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got[d].size() !== exp_q[d].size()) begin
        errors++;
        $display("FAIL %s_nwrites[%0d]: got %0d writes, required %0d", name, d, got[d].size(), exp_q[d].size());
      end else begin
        for (int k = 0; k < got[d].size(); k++) begin
          checks++;
          if (got[d][k].addr !== exp_q[d][k].addr || got[d][k].data !== exp_q[d][k].data) begin
            errors++;
            $display("FAIL %s_write[%0d][%0d]: addr=%0d data=%h, required addr=%0d data=%h", name, d, k,
                     got[d][k].addr, got[d][k].data, exp_q[d][k].addr, exp_q[d][k].data);
          end
        end
      end
      checks++;
      if (obs_cnt[d] !== 9'(exp_cnt[d]) || obs_done[d] !== exp_done[d] || obs_ovf[d] !== exp_ovf[d]) begin
        errors++;
        $display("FAIL %s_status[%0d]: count=%0d done=%0b ovf=%0b, required %0d %0b %0b", name, d,
                 obs_cnt[d], obs_done[d], obs_ovf[d], exp_cnt[d], exp_done[d], exp_ovf[d]);
      end
    end
  endtask

  task automatic test_ignore();
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    gen_words(2, 1'b0);
    clear_got();
    send(0, 7, 0);
    checks++;
    if (got[0].size() !== 0 || got[1].size() !== 0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: writes=%0d/%0d busy=%0b done=%0b, required 0/0 0 0",
               got[0].size(), got[1].size(), busy_a, done_a);
    end
    gen_words(1, 1'b1);
    compute_expected();
    clear_got();
    do_start();
    send(0, 1, 1);
    do_start();
    send(2, 7, 1);
    checks++;
    if (got[0].size() !== 2 || got[0][0].addr !== 32'd0 || got[0][0].data !== exp_q[0][0].data ||
        got[0][1].addr !== 32'd4 || cnt_a !== 9'd2 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start: writes=%0d count=%0d done=%0b, required 2 writes (word %h at 0, halt at 4) 2 1",
               got[0].size(), cnt_a, done_a, exp_q[0][0].data);
    end
    gen_words(2, 1'b1);
    clear_got();
    send(0, 11, 0);
    checks++;
    if (got[0].size() !== 0 || got[1].size() !== 0 || done_a !== 1'b1 || cnt_a !== 9'd2) begin
      errors++;
      $display("FAIL ignore_done: writes=%0d/%0d done=%0b count=%0d, required 0/0 1 2",
               got[0].size(), got[1].size(), done_a, cnt_a);
    end
  endtask

  task automatic test_reset_mid();
    gen_words(1, 1'b0);
    clear_got();
    do_start();
    send(0, 2, 0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_a, ins_a, addr_a, busy_a, done_a, ovf_a, cnt_a} !== 77'd0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%h, required all zero", {wr_a, ins_a, addr_a, busy_a, done_a, ovf_a, cnt_a});
    end
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = bytes[3];
    @(posedge clk); #1 rx_valid = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (got[0].size() !== 0 || got[1].size() !== 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nowrite: writes=%0d/%0d busy=%0b, required 0/0 0", got[0].size(), got[1].size(), busy_a);
    end
    test_session("after_reset", 1, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_session("back_to_back", 2, 0, 1'b1);
    test_session("overflow", 6, 2, 1'b1);
    test_ignore();
    test_reset_mid();
    test_session("restart", 2, 3, 1'b1);
    for (int s = 0; s < 6; s++) test_session("random", $urandom_range(7, 0), $urandom_range(3, 0), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
